// File: rtl/dac_spi_driver.sv
// -----------------------------------------------------------------------------
// dac_spi_driver
//
// Purpose:
//   Final stage of the audio path. A free-running sample divider produces one
//   tick every SAMPLE_DIV clocks. On each tick the 12-bit mixer word is
//   captured into a 16-bit MCP4921-style frame:
//     {~A/B=0, BUF, ~GA=GAIN_1X, ~SHDN=1, audio[11:0]}
//   The frame is shifted out MSB first in SPI mode 0 and followed by an LDAC
//   strobe. Every phase of the transfer lasts SCK_HALF clocks.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   audio[11:0]  mixer output, sampled only on the tick cycle
//   cs_n         DAC chip select, active low
//   sck          SPI clock, idles low
//   sdi          SPI data to the DAC
//   ldac_n       DAC latch strobe, active low
//   sample_tick  one-cycle pulse per sample period
//   busy         high while a frame or the LDAC strobe is in progress
//   overrun      sticky; set when a tick arrives while busy
// -----------------------------------------------------------------------------
module dac_spi_driver #(
    parameter int   SCK_HALF   = 2,
    parameter int   SAMPLE_DIV = 2500,
    parameter logic BUF        = 1'b0,
    parameter logic GAIN_1X    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] audio,
    output logic        cs_n,
    output logic        sck,
    output logic        sdi,
    output logic        ldac_n,
    output logic        sample_tick,
    output logic        busy,
    output logic        overrun
);

    localparam int CNT_W  = $clog2(SAMPLE_DIV);
    localparam int HALF_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCK_HALF - 1);
    localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL,
        ST_LDAC
    } state_t;

    // Registered state
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [3:0]          bit_q, bit_d;
    // Holds frame bits 14..0; bit 15 goes straight onto sdi at capture time.
    logic [14:0]         shreg_q, shreg_d;
    logic                cs_n_q, cs_n_d;
    logic                sck_q, sck_d;
    logic                sdi_q, sdi_d;
    logic                ldac_n_q, ldac_n_d;
    logic                sample_tick_q, sample_tick_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;

    logic                tick;
    logic                half_end;
    logic [15:0]         frame_w;

    assign frame_w = {1'b0, BUF, GAIN_1X, 1'b1, audio};

    always_comb begin
        // Sample divider runs regardless of the transfer state.
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_ONE;

        half_end = (half_q == HALF_LAST);
        half_d   = half_end ? '0 : half_q + HALF_ONE;

        state_d       = state_q;
        bit_d         = bit_q;
        shreg_d       = shreg_q;
        cs_n_d        = cs_n_q;
        sck_d         = sck_q;
        sdi_d         = sdi_q;
        ldac_n_d      = ldac_n_q;
        busy_d        = busy_q;
        sample_tick_d = tick;
        // A tick during a transfer is dropped; only the sticky flag records it.
        overrun_d     = overrun_q | (tick & busy_q);

        case (state_q)
            ST_IDLE: begin
                half_d   = '0;
                cs_n_d   = 1'b1;
                sck_d    = 1'b0;
                sdi_d    = 1'b0;
                ldac_n_d = 1'b1;
                busy_d   = 1'b0;
                if (tick) begin
                    shreg_d = frame_w[14:0];
                    sdi_d   = frame_w[15];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = 4'd15;
                    state_d = ST_LEAD;
                end
            end

            ST_LEAD: begin
                if (half_end) begin
                    sck_d   = 1'b1;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (half_end) begin
                    if (sck_q) begin
                        // Falling edge: present the next bit, except after bit 0.
                        sck_d = 1'b0;
                        if (bit_q != 4'd0) begin
                            sdi_d   = shreg_q[14];
                            shreg_d = {shreg_q[13:0], 1'b0};
                        end
                    end else begin
                        // End of a low phase: either start the next slot or,
                        // after bit 0's slot, leave the shift phase.
                        if (bit_q == 4'd0) begin
                            state_d = ST_TRAIL;
                        end else begin
                            bit_d = bit_q - 4'd1;
                            sck_d = 1'b1;
                        end
                    end
                end
            end

            ST_TRAIL: begin
                if (half_end) begin
                    cs_n_d   = 1'b1;
                    ldac_n_d = 1'b0;
                    sdi_d    = 1'b0;
                    state_d  = ST_LDAC;
                end
            end

            ST_LDAC: begin
                if (half_end) begin
                    ldac_n_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            half_q        <= '0;
            bit_q         <= 4'd0;
            shreg_q       <= '0;
            cs_n_q        <= 1'b1;
            sck_q         <= 1'b0;
            sdi_q         <= 1'b0;
            ldac_n_q      <= 1'b1;
            sample_tick_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            half_q        <= half_d;
            bit_q         <= bit_d;
            shreg_q       <= shreg_d;
            cs_n_q        <= cs_n_d;
            sck_q         <= sck_d;
            sdi_q         <= sdi_d;
            ldac_n_q      <= ldac_n_d;
            sample_tick_q <= sample_tick_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign cs_n        = cs_n_q;
    assign sck         = sck_q;
    assign sdi         = sdi_q;
    assign ldac_n      = ldac_n_q;
    assign sample_tick = sample_tick_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule
